// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game blocks.
// State and obstacle enums, slot bundle, screen width, LFSR seed/taps.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CRASHED = 2'd2
  } state_e;

  typedef enum logic {
    OBS_CACTUS = 1'b0,
    OBS_BIRD   = 1'b1
  } obs_kind_e;

  localparam int SCREEN_W = 64;
  localparam int X_W      = 6;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps at bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    obs_kind_e      kind;
  } slot_t;

  function automatic logic lfsr_fb(input logic [7:0] l);
    return ^(l & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left, advances when advance is high.
// Ports: clk, reset (sync, active-high), advance, value[7:0].
module lfsr8
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = {value_q[6:0], lfsr_fb(value_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/obstacle_field.sv
// Obstacle spawner, scroller, collision detector and score keeper.
// Ports: clk, reset (sync, active-high), game_tick, game_start_pulse,
//   player_position[5:0], ducking -> crash, obs_valid[1:0],
//   obs_x[11:0] ({slot1,slot0}), obs_type[1:0], score[7:0].
// Macro OBSTACLE_BIRD_EN enables bird spawns and the bird hit rule.
module obstacle_field
  import dino_pkg::*;
#(
  parameter int PLAYER_X = 8,
  parameter int PLAYER_H = 10,
  parameter int CACTUS_H = 6,
  parameter int BIRD_LO  = 8,
  parameter int MIN_GAP  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_tick,
  input  logic        game_start_pulse,
  input  logic [5:0]  player_position,
  input  logic        ducking,
  output logic        crash,
  output logic [1:0]  obs_valid,
  output logic [11:0] obs_x,
  output logic [1:0]  obs_type,
  output logic [7:0]  score
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);

  state_e         state_q, state_d;
  slot_t          slot_q [2];
  slot_t          slot_d [2];
  logic [7:0]     score_q, score_d;
  logic           crash_q, crash_d;
  logic [X_W-1:0] gap_q, gap_d;

  logic           lfsr_adv;
  logic [7:0]     lfsr;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .value   (lfsr)
  );

  // Vertical overlap terms, 7 bits wide so sums never wrap.
  logic [6:0] pos7;
  logic       cactus_v;

  assign pos7     = {1'b0, player_position};
  assign cactus_v = pos7 < 7'(CACTUS_H);

  obs_kind_e spawn_kind;
  logic      unused_sink;

`ifdef OBSTACLE_BIRD_EN
  logic [6:0] h7;
  logic       bird_v;

  assign h7 = ducking ? 7'(PLAYER_H / 2) : 7'(PLAYER_H);
  // Player rows pos..pos+h-1 meet bird rows BIRD_LO..BIRD_LO+5.
  assign bird_v = (pos7 <= 7'(BIRD_LO + 5)) &&
                  ((pos7 + h7) > 7'(BIRD_LO));
  assign spawn_kind  = obs_kind_e'(lfsr[0]);
  assign unused_sink = ^lfsr[7:5];
`else
  assign spawn_kind  = OBS_CACTUS;
  assign unused_sink = ^{lfsr[7:5], lfsr[0], ducking};
`endif

  logic [1:0] hit_s;
  logic       hit;

  always_comb begin
    hit_s = '0;
    for (int s = 0; s < 2; s++) begin
      if (slot_q[s].valid &&
          slot_q[s].x >= X_W'(PLAYER_X) &&
          slot_q[s].x <= X_W'(PLAYER_X + 3)) begin
`ifdef OBSTACLE_BIRD_EN
        hit_s[s] = (slot_q[s].kind == OBS_BIRD) ? bird_v : cactus_v;
`else
        hit_s[s] = cactus_v;
`endif
      end
    end
  end

  assign hit = |hit_s;

  slot_t          spawn_slot;
  logic [X_W-1:0] gap_reload;

  assign spawn_slot = '{valid: 1'b1, x: X_MAX, kind: spawn_kind};
  assign gap_reload = X_W'(MIN_GAP) + {2'b00, lfsr[4:1]};

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    score_d  = score_q;
    crash_d  = crash_q;
    gap_d    = gap_q;
    lfsr_adv = 1'b0;

    if (game_start_pulse) begin
      state_d = ST_RUN;
      slot_d  = '{default: '0};
      score_d = '0;
      crash_d = 1'b0;
      gap_d   = X_W'(MIN_GAP);
    end else if (state_q == ST_RUN) begin
      if (hit) begin
        // Overlap freezes the field; a tick this cycle is dropped.
        state_d = ST_CRASHED;
        crash_d = 1'b1;
      end else if (game_tick) begin
        lfsr_adv = 1'b1;
        for (int s = 0; s < 2; s++) begin
          if (slot_q[s].valid) begin
            if (slot_q[s].x == '0) begin
              slot_d[s] = '0;
              if (score_d != 8'hFF) begin
                score_d = score_d + 8'd1;
              end
            end else begin
              slot_d[s].x = slot_q[s].x - 1'b1;
            end
          end
        end
        // Free slots are judged on registered valids, so a slot
        // wrapping this tick is only reusable next tick.
        if (gap_q == '0) begin
          if (!slot_q[0].valid) begin
            slot_d[0] = spawn_slot;
            gap_d     = gap_reload;
          end else if (!slot_q[1].valid) begin
            slot_d[1] = spawn_slot;
            gap_d     = gap_reload;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      crash_q <= 1'b0;
      gap_q   <= '0;
      for (int s = 0; s < 2; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      crash_q <= crash_d;
      gap_q   <= gap_d;
      for (int s = 0; s < 2; s++) begin
        slot_q[s] <= slot_d[s];
      end
    end
  end

  assign crash     = crash_q;
  assign obs_valid = {slot_q[1].valid, slot_q[0].valid};
  assign obs_x     = {slot_q[1].x, slot_q[0].x};
  assign obs_type  = {slot_q[1].kind, slot_q[0].kind};
  assign score     = score_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Self-checking bench for obstacle_field: directed sequences,
// a geometry table and random stimulus against a reference model.
module tb_obstacle_field;

`ifdef OBSTACLE_BIRD_EN
  localparam bit BIRD = 1'b1;
`else
  localparam bit BIRD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        game_tick;
  logic        game_start_pulse;
  logic [5:0]  player_position;
  logic        ducking;
  logic        crash;
  logic [1:0]  obs_valid;
  logic [11:0] obs_x;
  logic [1:0]  obs_type;
  logic [7:0]  score;

  obstacle_field dut (
    .clk              (clk),
    .reset            (rst),
    .game_tick        (game_tick),
    .game_start_pulse (game_start_pulse),
    .player_position  (player_position),
    .ducking          (ducking),
    .crash            (crash),
    .obs_valid        (obs_valid),
    .obs_x            (obs_x),
    .obs_type         (obs_type),
    .score            (score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: game described directly from the rules.
  bit m_run, m_crashed;
  int m_valid [2];
  int m_x     [2];
  int m_type  [2];
  int m_score, m_crash, m_gap, m_lfsr;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = 0;
      m_x[s]     = 0;
      m_type[s]  = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit tk, input int p,
                            input bit dk);
    bit hit;
    int free_s;
    int h;
    if (rst) begin
      m_clear();
      m_run = 0; m_crashed = 0;
      m_score = 0; m_crash = 0; m_gap = 0; m_lfsr = 165;
      return;
    end
    if (st) begin
      m_clear();
      m_run = 1; m_crashed = 0;
      m_score = 0; m_crash = 0; m_gap = 12;
      return;
    end
    if (!m_run) return;
    hit = 0;
    for (int s = 0; s < 2; s++) begin
      if (m_valid[s] != 0 && m_x[s] >= 8 && m_x[s] <= 11) begin
        if (m_type[s] == 0) begin
          if (p < 6) hit = 1;
        end else begin
          h = dk ? 5 : 10;
          if (p <= 13 && p + h - 1 >= 8) hit = 1;
        end
      end
    end
    if (hit) begin
      m_crash = 1; m_run = 0; m_crashed = 1;
      return;
    end
    if (!tk) return;
    free_s = -1;
    for (int s = 1; s >= 0; s--) begin
      if (m_valid[s] == 0) free_s = s;
    end
    for (int s = 0; s < 2; s++) begin
      if (m_valid[s] != 0) begin
        if (m_x[s] == 0) begin
          m_valid[s] = 0; m_type[s] = 0;
          if (m_score < 255) m_score++;
        end else begin
          m_x[s]--;
        end
      end
    end
    if (m_gap == 0) begin
      if (free_s >= 0) begin
        m_valid[free_s] = 1;
        m_x[free_s]     = 63;
        m_type[free_s]  = BIRD ? (m_lfsr & 1) : 0;
        m_gap           = 12 + ((m_lfsr >> 1) & 15);
      end
    end else begin
      m_gap--;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic cyc(input bit st, input bit tk, input int p,
                     input bit dk);
    game_start_pulse = st;
    game_tick        = tk;
    player_position  = 6'(p);
    ducking          = dk;
    @(posedge clk);
    model_step(st, tk, p, dk);
    #1;
    chk("crash", 32'(crash), 32'(m_crash));
    chk("valid", 32'(obs_valid), 32'(m_valid[1] * 2 + m_valid[0]));
    chk("x", 32'(obs_x), 32'(m_x[1] * 64 + m_x[0]));
    chk("type", 32'(obs_type), 32'(m_type[1] * 2 + m_type[0]));
    chk("score", 32'(score), 32'(m_score));
  endtask

  task automatic ticks(input int n, input int p, input bit dk);
    for (int i = 0; i < n; i++) cyc(0, 1, p, dk);
  endtask

  typedef struct {
    int pos;
    bit duck;
    bit exp_cactus;
    bit exp_bird;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int  exp_l;
    bit  found;
    bit  exp_c;

    vecs[0] = '{0,  1'b0, 1'b1, 1'b1};
    vecs[1] = '{0,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{5,  1'b0, 1'b1, 1'b1};
    vecs[3] = '{5,  1'b1, 1'b1, 1'b1};
    vecs[4] = '{6,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{13, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{14, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3,  1'b1, 1'b1, 1'b0};
    vecs[8] = '{4,  1'b1, 1'b1, 1'b1};
    vecs[9] = '{63, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_crash", 32'(crash), 0);
    chk("rst_valid", 32'(obs_valid), 0);
    chk("rst_x", 32'(obs_x), 0);
    chk("rst_score", 32'(score), 0);
    rst = 1'b0;

    // First spawn after the MIN_GAP countdown.
    cyc(0, 1, 20, 0);
    chk("idle_tick", 32'(obs_valid), 0);
    cyc(1, 0, 20, 0);
    ticks(12, 20, 0);
    chk("a_no_spawn", 32'(obs_valid), 0);
    ticks(1, 20, 0);
    exp_l = 165;
    for (int i = 0; i < 12; i++) exp_l = lfsr_next(exp_l);
    chk("a_valid", 32'(obs_valid[0]), 1);
    chk("a_x", 32'(obs_x[5:0]), 63);
    chk("a_type", 32'(obs_type[0]), BIRD ? 32'(exp_l & 1) : 0);
    chk("a_score", 32'(score), 0);

    // Scroll off the left edge while both slots are held.
    ticks(63, 20, 0);
    chk("b_x0", 32'(obs_x[5:0]), 0);
    chk("b_both", 32'(obs_valid), 3);
    ticks(1, 20, 0);
    chk("b_wrap_valid", 32'(obs_valid), 2);
    chk("b_score", 32'(score), 1);
    ticks(1, 20, 0);
    chk("b_respawn", 32'(obs_valid), 3);
    chk("b_respawn_x", 32'(obs_x[5:0]), 63);

    // Cactus hits a grounded player at x=11.
    cyc(1, 0, 0, 0);
    ticks(65, 0, 0);
    chk("c_x11", 32'(obs_x[5:0]), 11);
    chk("c_nocrash", 32'(crash), 0);
    ticks(1, 0, 0);
    chk("c_crash", 32'(crash), 1);
    chk("c_frozen", 32'(obs_x[5:0]), 11);
    ticks(5, 0, 0);
    chk("c_hold_x", 32'(obs_x[5:0]), 11);
    chk("c_hold_score", 32'(score), 0);
    chk("c_hold_crash", 32'(crash), 1);

    // Start and tick together while crashed.
    cyc(1, 1, 0, 0);
    chk("d_crash", 32'(crash), 0);
    chk("d_valid", 32'(obs_valid), 0);
    chk("d_x", 32'(obs_x), 0);
    chk("d_score", 32'(score), 0);
    ticks(5, 20, 0);
    chk("d_run", 32'(obs_valid), 0);

`ifdef OBSTACLE_BIRD_EN
    found = 1'b0;
    for (int a = 0; a < 16; a++) begin
      cyc(1, 0, 20, 0);
      ticks(13, 20, 0);
      if (m_type[0] == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("e_bird_found", 32'(found), 1);
    if (found) begin
      chk("e_type", 32'(obs_type[0]), 1);
      ticks(55, 20, 0);
      chk("e_x8", 32'(obs_x[5:0]), 8);
      cyc(0, 0, 0, 1);
      chk("e_duck", 32'(crash), 0);
      cyc(0, 0, 0, 0);
      chk("e_stand", 32'(crash), 1);
    end
`endif

    // Vertical geometry table at x=11.
    foreach (vecs[i]) begin
      cyc(1, 0, 20, 0);
      ticks(64, 20, 0);
      cyc(0, 1, vecs[i].pos, vecs[i].duck);
      cyc(0, 0, vecs[i].pos, vecs[i].duck);
      exp_c = (m_type[0] == 1) ? vecs[i].exp_bird : vecs[i].exp_cactus;
      chk($sformatf("tbl%0d", i), 32'(crash), 32'(exp_c));
    end

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      int  p;
      bit  st, tk, dk;
      rst = ($urandom_range(0, 599) == 0);
      st  = ($urandom_range(0, 119) == 0);
      tk  = ($urandom_range(0, 1) == 1);
      dk  = ($urandom_range(0, 1) == 1);
      p   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(16, 63));
      cyc(st, tk, p, dk);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
